serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 85 ++++++++
 1 files changed

// File: rtl/serial_tx.sv
// serial_tx: loads a parallel word and shifts it out MSB first. Each frame
// is followed by a one-cycle gap carrying a done pulse. In repeat mode the
// current data_in is reloaded after every gap, so transmission is continuous
// with a period of NBITS+1 cycles.
module serial_tx #(
    parameter int NBITS       = 8,
    parameter int NBITS_COUNT = 4
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       repeat_mode,
    input  logic [NBITS-1:0]           data_in,
    output logic                       serial_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NBITS)-1:0]   bit_idx,
    output logic [NBITS_COUNT-1:0]     frame_count
);

    localparam int IDX_W = $clog2(NBITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

    logic [1:0]       state;
    logic [NBITS-1:0] shreg;

    // Frame sequencer: load, shift out, one gap cycle, then idle or reload.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            frame_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= data_in;
                        bit_idx <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_idx == LAST_IDX) begin
                        state       <= GAP;
                        done        <= 1'b1;
                        frame_count <= frame_count + NBITS_COUNT'(1);
                        bit_idx     <= '0;
                    end else begin
                        shreg   <= {shreg[NBITS-2:0], 1'b0};
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                GAP: begin
                    if (repeat_mode) begin
                        // Reload takes the value present now, not the one
                        // captured at the original start.
                        shreg   <= data_in;
                        bit_idx <= '0;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded straight from the state so they react to reset at once.
    always_comb begin
        busy       = (state == SHIFT) || (state == GAP);
        serial_out = (state == SHIFT) ? shreg[NBITS-1] : 1'b0;
    end

endmodule
